rv_regs_ctrl: RTL
=================

# rv_regs_ctrl

Controller in front of the core register file (32×32, one write port, two synchronous read ports with one-cycle latency and read-old-data on same-address collision). Sits between the decode/writeback stages, the debug module and the register file. It zero-clears x1..x31 after reset, shares the file's ports between the core and a debug requester, forces x0 reads to zero, and bypasses same-cycle write data onto the read results.

## Interface
- No parameters; widths fixed: XLEN 32, 5-bit register index.
- Clock and reset: i_clk, i_reset_n, synchronous, active-low.
- i_clk  in  1  clock
- i_reset_n  in  1  synchronous active-low reset
- i_rs1, i_rs2  in  5  core read indices
- i_rd  in  5  core write index
- i_wr  in  1  core write enable
- i_wdata  in  32  core write data
- o_rdata1, o_rdata2  out  32  core read results, valid when o_rd_valid
- o_rd_valid  out  1  read results correspond to indices accepted the previous cycle
- o_ready  out  1  core port accepted this cycle (low during clear and debug access)
- i_dbg_req  in  1  debug request, held until o_dbg_ack
- i_dbg_we  in  1  debug write (1) or read (0)
- i_dbg_addr  in  5  debug register index
- i_dbg_wdata  in  32  debug write data
- o_dbg_ack  out  1  one-cycle completion pulse
- o_dbg_rdata  out  32  debug read data, valid with o_dbg_ack
- o_rf_rs1, o_rf_rs2, o_rf_rd  out  5  register-file indices
- o_rf_write  out  1  register-file write enable
- o_rf_data  out  32  register-file write data
- i_rf_data1, i_rf_data2  in  32  register-file read data

## Operation
- States: CLEAR, RUN, DBG_ACC, DBG_RSP.
- CLEAR (entered on reset):
  - 5-bit counter starts at 1; each cycle drives o_rf_rd = cnt, o_rf_write = 1, o_rf_data = 0; counter increments.
  - After writing index 31, go to RUN (31 clear cycles).
  - Core inputs ignored; a debug request stays pending.
- RUN:
  - Core owns the ports: o_rf_rs1/2 = i_rs1/2, o_rf_rd = i_rd, o_rf_write = i_wr && i_rd≠0, o_rf_data = i_wdata; o_ready = 1.
  - Go to DBG_ACC if i_dbg_req and no core write is active this cycle (i_wr && i_rd≠0). The core write has priority; debug waits.
- DBG_ACC:
  - o_ready = 0; o_rf_rs1 = i_dbg_addr.
  - If i_dbg_we and i_dbg_addr≠0: o_rf_write = 1, o_rf_rd = i_dbg_addr, o_rf_data = i_dbg_wdata.
  - Always go to DBG_RSP.
- DBG_RSP:
  - o_dbg_ack = 1.
  - o_dbg_rdata = read result for i_dbg_addr, with bypass and x0 rules applied; 0 for writes.
  - o_ready = 1 (core accepted again); go to RUN.
- Read rules, per port:
  - Register the presented index, and register whether a file write to that same nonzero index occurred in the same cycle, together with its data.
  - Next cycle: result = 0 if index 0; else the registered write data if a collision occurred; else i_rf_data.
- o_rd_valid = o_ready registered.
- Reset mid-operation (any state): next state CLEAR, counter 1, o_dbg_ack 0. A debug access that was in flight is dropped; the requester reissues.

## Timing
- Reset values: o_ready 0, o_rd_valid 0, o_dbg_ack 0, o_dbg_rdata 0, o_rdata1/2 0, o_rf_write 1 (first clear cycle), o_rf_rd 1.
- Read latency: 1 cycle (indices at edge N, data at N+1 with o_rd_valid).
- Write visibility: a write at edge N is returned by a read presented at N via bypass.
- Debug latency: grant + 2 cycles; o_dbg_ack exactly one cycle; the requester drops i_dbg_req the cycle after the ack.
- Core throughput loss per debug access: 1 cycle (DBG_ACC).

## Structure
- Package rv_regs_pkg: state enum (CLEAR, RUN, DBG_ACC, DBG_RSP), REG_IDX_W = 5, XLEN = 32, REG_LAST = 31.
- Sub-module rv_regs_bypass, instantiated once per read port. It registers index, collision flag and write data, and muxes the result.
- FSM and clear counter in rv_regs_ctrl.

## Test plan
- Reset: release reset, check 31 writes of 0 to x1..x31 and o_ready low for 31 cycles, then read x5 -> 0.
- Bypass: core writes x7 = 0xDEADBEEF with rs1 = 7 in the same cycle -> next cycle o_rdata1 = 0xDEADBEEF.
- x0: core writes x0 = 0x1234 -> o_rf_write 0; a read of x0 -> 0.
- Debug: debug write x3 = 0xA5A5A5A5 -> ack 2 cycles after grant, o_ready low 1 cycle; debug read x3 -> o_dbg_rdata = 0xA5A5A5A5.
- Priority: debug request asserted while the core writes x9 every cycle for 4 cycles -> grant only on the first non-write cycle; x9 holds the last core data.
- Mid-operation reset: reset asserted during DBG_ACC -> no ack, full clear sequence, then a debug read of x3 -> 0.

Source files
------------

// File: rtl/rv_regs_pkg.sv
// Shared widths, indices and FSM state encoding for the register-file controller.
package rv_regs_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_LAST = 5'd31;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      xword_t;

    typedef enum logic [1:0] {
        CLEAR,
        RUN,
        DBG_ACC,
        DBG_RSP
    } state_e;

endpackage

// File: rtl/rv_regs_ctrl_if.sv
// Core and debug request/response bundle of the register-file controller.
interface rv_regs_ctrl_if;
    import rv_regs_pkg::*;

    reg_idx_t rs1;
    reg_idx_t rs2;
    reg_idx_t rd;
    logic     wr;
    xword_t   wdata;
    xword_t   rdata1;
    xword_t   rdata2;
    logic     rd_valid;
    logic     ready;

    logic     dbg_req;
    logic     dbg_we;
    reg_idx_t dbg_addr;
    xword_t   dbg_wdata;
    logic     dbg_ack;
    xword_t   dbg_rdata;

    modport master (
        output rs1, rs2, rd, wr, wdata, dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  rdata1, rdata2, rd_valid, ready, dbg_ack, dbg_rdata
    );

    modport slave (
        input  rs1, rs2, rd, wr, wdata, dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output rdata1, rdata2, rd_valid, ready, dbg_ack, dbg_rdata
    );

endinterface

// File: rtl/rv_regs_bypass.sv
// One read port: registers the presented index plus any same-cycle write to it,
// then returns zero for x0, the forwarded write data, or the file's read data.
module rv_regs_bypass
    import rv_regs_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_reset_n,
    input  reg_idx_t i_idx,
    input  logic     i_wr_en,
    input  reg_idx_t i_wr_idx,
    input  xword_t   i_wr_data,
    input  xword_t   i_rf_data,
    output xword_t   o_result
);

    reg_idx_t idx_q, idx_d;
    logic     hit_q, hit_d;
    xword_t   data_q, data_d;

    always_comb begin
        idx_d  = i_idx;
        hit_d  = i_wr_en && (i_wr_idx == i_idx) && (i_idx != '0);
        data_d = i_wr_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            idx_q  <= '0;
            hit_q  <= 1'b0;
            data_q <= '0;
        end else begin
            idx_q  <= idx_d;
            hit_q  <= hit_d;
            data_q <= data_d;
        end
    end

    // The file returns old data on a same-address collision, so forward the write.
    assign o_result = (idx_q == '0) ? '0 : (hit_q ? data_q : i_rf_data);

endmodule

// File: rtl/rv_regs_ctrl.sv
// Register-file front end: post-reset zero clear of x1..x31, core/debug port
// sharing, x0 read forcing and same-cycle write bypass.
module rv_regs_ctrl
    import rv_regs_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_reset_n,
    input  reg_idx_t i_rs1,
    input  reg_idx_t i_rs2,
    input  reg_idx_t i_rd,
    input  logic     i_wr,
    input  xword_t   i_wdata,
    output xword_t   o_rdata1,
    output xword_t   o_rdata2,
    output logic     o_rd_valid,
    output logic     o_ready,
    input  logic     i_dbg_req,
    input  logic     i_dbg_we,
    input  reg_idx_t i_dbg_addr,
    input  xword_t   i_dbg_wdata,
    output logic     o_dbg_ack,
    output xword_t   o_dbg_rdata,
    output reg_idx_t o_rf_rs1,
    output reg_idx_t o_rf_rs2,
    output reg_idx_t o_rf_rd,
    output logic     o_rf_write,
    output xword_t   o_rf_data,
    input  xword_t   i_rf_data1,
    input  xword_t   i_rf_data2
);

    state_e   state_q, state_d;
    reg_idx_t cnt_q, cnt_d;
    logic     rd_valid_q, rd_valid_d;
    logic     core_wr;
    xword_t   rdata1_int;
    xword_t   rdata2_int;

    assign core_wr = i_wr && (i_rd != '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        o_ready    = 1'b0;
        o_dbg_ack  = 1'b0;
        o_rf_rs1   = i_rs1;
        o_rf_rs2   = i_rs2;
        o_rf_rd    = i_rd;
        o_rf_write = 1'b0;
        o_rf_data  = i_wdata;
        case (state_q)
            CLEAR: begin
                o_rf_rd    = cnt_q;
                o_rf_write = 1'b1;
                o_rf_data  = '0;
                cnt_d      = cnt_q + 5'd1;
                if (cnt_q == REG_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                o_ready    = 1'b1;
                o_rf_write = core_wr;
                // A core write owns the single write port; debug waits for a gap.
                if (i_dbg_req && !core_wr) begin
                    state_d = DBG_ACC;
                end
            end
            DBG_ACC: begin
                o_rf_rs1 = i_dbg_addr;
                if (i_dbg_we && (i_dbg_addr != '0)) begin
                    o_rf_write = 1'b1;
                    o_rf_rd    = i_dbg_addr;
                    o_rf_data  = i_dbg_wdata;
                end
                state_d = DBG_RSP;
            end
            DBG_RSP: begin
                o_ready    = 1'b1;
                o_dbg_ack  = 1'b1;
                o_rf_write = core_wr;
                state_d    = RUN;
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = 5'd1;
            end
        endcase
        rd_valid_d = o_ready;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q    <= CLEAR;
            cnt_q      <= 5'd1;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    rv_regs_bypass u_byp1 (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_idx     (o_rf_rs1),
        .i_wr_en   (o_rf_write),
        .i_wr_idx  (o_rf_rd),
        .i_wr_data (o_rf_data),
        .i_rf_data (i_rf_data1),
        .o_result  (rdata1_int)
    );

    rv_regs_bypass u_byp2 (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_idx     (o_rf_rs2),
        .i_wr_en   (o_rf_write),
        .i_wr_idx  (o_rf_rd),
        .i_wr_data (o_rf_data),
        .i_rf_data (i_rf_data2),
        .o_result  (rdata2_int)
    );

    assign o_rdata1    = rdata1_int;
    assign o_rdata2    = rdata2_int;
    assign o_rd_valid  = rd_valid_q;
    // Debug reads go through port 1, which carries i_dbg_addr during DBG_ACC.
    assign o_dbg_rdata = (o_dbg_ack && !i_dbg_we) ? rdata1_int : '0;

endmodule
